// File: rtl/q312_pkg.sv
// Shared constants and FSM state type for the Q3.12 Givens coefficient datapath.
package q312_pkg;
   localparam int               Q_FRAC     = 12;
   localparam int               W          = 16;
   localparam logic [W-1:0]     Q_ONE      = 16'h1000;
   localparam int               SQRT_ITERS = 16;
   localparam int               DIV_ITERS  = 13;

   typedef enum logic [2:0] {
      IDLE,
      SQ,
      SQRT,
      DIV,
      DONE
   } state_e;
endpackage

// File: rtl/q312_div_seq.sv
// Sequential restoring divider: load captures operands, each step retires one quotient bit.
module q312_div_seq
   import q312_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   load_i,
   input  logic                   step_i,
   input  logic [DIV_ITERS+W-1:0] dividend_i,
   input  logic [W-1:0]           divisor_i,
   output logic [DIV_ITERS-1:0]   quotient_o
);
   logic [W-1:0]         rem_q, rem_d;
   logic [DIV_ITERS-1:0] shr_q, shr_d;
   logic [W-1:0]         dsr_q, dsr_d;
   logic [W:0]           trial;
   logic                 ge;

   // Upper dividend bits seed the remainder; valid because the quotient always fits DIV_ITERS bits.
   always_comb begin
      rem_d = rem_q;
      shr_d = shr_q;
      dsr_d = dsr_q;
      trial = {rem_q, shr_q[DIV_ITERS-1]};
      ge    = (trial >= {1'b0, dsr_q});
      if (load_i) begin
         rem_d = dividend_i[DIV_ITERS+W-1:DIV_ITERS];
         shr_d = dividend_i[DIV_ITERS-1:0];
         dsr_d = divisor_i;
      end else if (step_i) begin
         rem_d = ge ? W'(trial - {1'b0, dsr_q}) : trial[W-1:0];
         shr_d = {shr_q[DIV_ITERS-2:0], ge};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem_q <= '0;
         shr_q <= '0;
         dsr_q <= '0;
      end else begin
         rem_q <= rem_d;
         shr_q <= shr_d;
         dsr_q <= dsr_d;
      end
   end

   assign quotient_o = shr_q;
endmodule

// File: rtl/givens_coeff_gen.sv
// Computes cos/sin/r of the x-axis Givens rotation that maps (y, z) to (r, 0).
//  state | meaning
//  IDLE  | waiting for start
//  SQ    | magnitudes, signs and y^2+z^2
//  SQRT  | bit-serial integer square root, one result bit per cycle
//  DIV   | two parallel restoring dividers |y|/r, |z|/r
//  DONE  | results presented with done pulse
module givens_coeff_gen
   import q312_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [W-1:0] y_in,
   input  logic [W-1:0] z_in,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] cos3,
   output logic [W-1:0] sin3,
   output logic [W-1:0] r_out
);
   state_e               state_q, state_d;
   logic [3:0]           cnt_q, cnt_d;
   logic [W-1:0]         y_q, z_q;
   logic [W:0]           mag_y_q, mag_z_q, mag_y, mag_z;
   logic                 sgn_y_q, sgn_z_q;
   logic [31:0]          rad_q, sq_sum;
   logic [17:0]          srem_q, rem_nxt;
   logic [W-1:0]         root_q, root_nxt, r_q;
   logic [19:0]          rem_sh, sq_trial;
   logic                 sq_ge;
   logic [W-1:0]         cos_q, sin_q, rout_q;
   logic [DIV_ITERS-1:0] qc, qs;
   logic [W-1:0]         qc_ext, qs_ext, cos_new, sin_new;
   logic                 div_load, div_step, zero_r;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: if (start) state_d = SQ;
         SQ: begin
            state_d = SQRT;
            cnt_d   = 4'(SQRT_ITERS - 1);
         end
         SQRT: begin
            if (cnt_q == 4'd0) begin
               state_d = DIV;
               cnt_d   = 4'(DIV_ITERS - 1);
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         DIV: begin
            if (cnt_q == 4'd0) state_d = DONE;
            else               cnt_d   = cnt_q - 4'd1;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign mag_y  = y_q[W-1] ? (17'd0 - {y_q[W-1], y_q}) : {1'b0, y_q};
   assign mag_z  = z_q[W-1] ? (17'd0 - {z_q[W-1], z_q}) : {1'b0, z_q};
   assign sq_sum = 32'(mag_y) * 32'(mag_y) + 32'(mag_z) * 32'(mag_z);

   assign rem_sh   = {srem_q, rad_q[31:30]};
   assign sq_trial = {2'b00, root_q, 2'b01};
   assign sq_ge    = (rem_sh >= sq_trial);
   assign rem_nxt  = sq_ge ? 18'(rem_sh - sq_trial) : rem_sh[17:0];
   assign root_nxt = {root_q[W-2:0], sq_ge};

   // Dividers load with the final root bit straight from the last SQRT step.
   assign div_load = (state_q == SQRT) && (cnt_q == 4'd0);
   assign div_step = (state_q == DIV);

   q312_div_seq u_div_c (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (div_load),
      .step_i     (div_step),
      .dividend_i ({mag_y_q, {Q_FRAC{1'b0}}}),
      .divisor_i  (root_nxt),
      .quotient_o (qc)
   );

   q312_div_seq u_div_s (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (div_load),
      .step_i     (div_step),
      .dividend_i ({mag_z_q, {Q_FRAC{1'b0}}}),
      .divisor_i  (root_nxt),
      .quotient_o (qs)
   );

   assign zero_r  = (r_q == '0);
   assign qc_ext  = {3'b000, qc};
   assign qs_ext  = {3'b000, qs};
   assign cos_new = zero_r ? Q_ONE : (sgn_y_q ? (16'd0 - qc_ext) : qc_ext);
   assign sin_new = zero_r ? '0    : (sgn_z_q ? qs_ext : (16'd0 - qs_ext));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_q     <= '0;
         z_q     <= '0;
         mag_y_q <= '0;
         mag_z_q <= '0;
         sgn_y_q <= 1'b0;
         sgn_z_q <= 1'b0;
         rad_q   <= '0;
         srem_q  <= '0;
         root_q  <= '0;
         r_q     <= '0;
         cos_q   <= Q_ONE;
         sin_q   <= '0;
         rout_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  y_q <= y_in;
                  z_q <= z_in;
               end
            end
            SQ: begin
               mag_y_q <= mag_y;
               mag_z_q <= mag_z;
               sgn_y_q <= y_q[W-1];
               sgn_z_q <= z_q[W-1];
               rad_q   <= sq_sum;
               srem_q  <= '0;
               root_q  <= '0;
            end
            SQRT: begin
               rad_q  <= {rad_q[29:0], 2'b00};
               srem_q <= rem_nxt;
               root_q <= root_nxt;
               if (cnt_q == 4'd0) r_q <= root_nxt;
            end
            DONE: begin
               cos_q  <= cos_new;
               sin_q  <= sin_new;
               rout_q <= r_q;
            end
            default: ;
         endcase
      end
   end

   // Fresh results are shown during the done pulse and held in the *_q copies afterwards.
   assign busy  = (state_q == SQ) || (state_q == SQRT) || (state_q == DIV);
   assign done  = (state_q == DONE);
   assign cos3  = done ? cos_new : cos_q;
   assign sin3  = done ? sin_new : sin_q;
   assign r_out = done ? r_q     : rout_q;
endmodule

// File: tb/tb_givens_coeff_gen.sv
// Directed bench for givens_coeff_gen with hand-computed expected values.
module tb_givens_coeff_gen;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [15:0] y_in = '0;
   logic [15:0] z_in = '0;
   logic        busy, done;
   logic [15:0] cos3, sin3, r_out;
   int          n_tests = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   givens_coeff_gen u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .y_in  (y_in),
      .z_in  (z_in),
      .busy  (busy),
      .done  (done),
      .cos3  (cos3),
      .sin3  (sin3),
      .r_out (r_out)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Called one cycle after the last clock edge, in IDLE; leaves the bench one cycle after done.
   task automatic run_op(input string tag, input logic [15:0] y, input logic [15:0] z,
                         input logic [15:0] ec, input logic [15:0] es, input logic [15:0] er,
                         input bit dup_start);
      int n;
      y_in  = y;
      z_in  = z;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check({tag, "/busy"}, 32'(busy), 32'd1);
      n = 0;
      while (!done && n < 40) begin
         if (dup_start && n == 10) begin
            start = 1'b1;
            y_in  = 16'h0000;
            z_in  = 16'h0000;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         n++;
      end
      start = 1'b0;
      check({tag, "/latency"}, 32'(n), 32'd30);
      check({tag, "/cos3"}, 32'(cos3), 32'(ec));
      check({tag, "/sin3"}, 32'(sin3), 32'(es));
      check({tag, "/r_out"}, 32'(r_out), 32'(er));
      check({tag, "/busy_done"}, 32'(busy), 32'd0);
      @(posedge clk); #1;
      check({tag, "/done_pulse"}, 32'(done), 32'd0);
      check({tag, "/cos3_hold"}, 32'(cos3), 32'(ec));
      check({tag, "/r_hold"}, 32'(r_out), 32'(er));
   endtask

   initial begin
      bit done_seen;
      repeat (2) @(posedge clk);
      #1;
      check("rst/busy", 32'(busy), 32'd0);
      check("rst/done", 32'(done), 32'd0);
      check("rst/cos3", 32'(cos3), 32'h1000);
      check("rst/sin3", 32'(sin3), 32'h0000);
      check("rst/r_out", 32'(r_out), 32'h0000);
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_op("unit_y", 16'h1000, 16'h0000, 16'h1000, 16'h0000, 16'h1000, 1'b0);
      run_op("3_4_dup", 16'h3000, 16'h4000, 16'h0999, 16'hF334, 16'h5000, 1'b1);
      run_op("zero", 16'h0000, 16'h0000, 16'h1000, 16'h0000, 16'h0000, 1'b0);
      run_op("neg8", 16'h8000, 16'h0000, 16'hF000, 16'h0000, 16'h8000, 1'b0);

      // Abort mid-SQRT with a reset; outputs must return to reset values and no done may follow.
      y_in  = 16'h3000;
      z_in  = 16'h4000;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("abort/busy", 32'(busy), 32'd0);
      check("abort/cos3", 32'(cos3), 32'h1000);
      check("abort/sin3", 32'(sin3), 32'h0000);
      check("abort/r_out", 32'(r_out), 32'h0000);
      @(posedge clk); #1;
      rst_n = 1'b1;
      done_seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (done) done_seen = 1'b1;
      end
      check("abort/no_done", 32'(done_seen), 32'd0);

      run_op("diag", 16'h1000, 16'hF000, 16'h0B50, 16'h0B50, 16'h16A0, 1'b0);
      run_op("b2b", 16'h0000, 16'h1000, 16'h0000, 16'hF000, 16'h1000, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
